// File: rtl/steer_en_sense.sv
// Rider-presence and steering-enable sensing for the load cells.
// Each side is smoothed by a 4-sample moving average. The smoothed sum is
// compared against a hysteresis band around the minimum rider weight. The
// left/right imbalance is compared against 1/4 and 15/16 of that sum.
// A separate saturating timer is cleared by the steer-enable state machine.
//
// Input handshake: ld_vld is a single-cycle strobe with no back-pressure.
// lft_ld and rght_ld are captured together on every clk edge where ld_vld=1.
// The comparison outputs are registered from the filter state, so a sample
// captured at edge N is reflected after edge N+1. The outputs hold until the
// next strobe.
module steer_en_sense #(
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] HYSTERESIS       = 12'h040,
  parameter logic [26:0] TMR_CNT          = 27'd65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        ld_vld,
  input  logic        clr_tmr,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        tmr_full
);

  logic [11:0] hist_l [4];
  logic [11:0] hist_r [4];
  logic [13:0] acc_l, acc_r;
  logic [13:0] acc_l_nxt, acc_r_nxt;
  logic [2:0]  fill;
  logic        filt_rdy;
  logic [11:0] lft_avg, rght_avg;
  logic [12:0] sum;
  logic [11:0] diff;
  logic        gt_min_c, lt_min_c, d14_c, d1516_c;
  logic [26:0] tmr_cnt;

  // The running sum always holds the exact sum of the four history entries.
  // It therefore never exceeds 4*4095, and the 14-bit add/subtract is exact.
  assign acc_l_nxt = acc_l + 14'(lft_ld)  - 14'(hist_l[3]);
  assign acc_r_nxt = acc_r + 14'(rght_ld) - 14'(hist_r[3]);

  // Sample histories, running sums and fill count advance on each strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_l[i] <= '0;
        hist_r[i] <= '0;
      end
      acc_l <= '0;
      acc_r <= '0;
      fill  <= '0;
    end else if (ld_vld) begin
      hist_l[0] <= lft_ld;
      hist_r[0] <= rght_ld;
      for (int i = 1; i < 4; i++) begin
        hist_l[i] <= hist_l[i-1];
        hist_r[i] <= hist_r[i-1];
      end
      acc_l <= acc_l_nxt;
      acc_r <= acc_r_nxt;
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  assign filt_rdy = (fill == 3'd4);

  // Filtered values and the comparisons on them.
  // The difference tests are carried out at 17 bits so that 15*sum cannot overflow.
  always_comb begin
    lft_avg  = 12'(acc_l >> 2);
    rght_avg = 12'(acc_r >> 2);
    sum      = {1'b0, lft_avg} + {1'b0, rght_avg};
    diff     = (lft_avg >= rght_avg) ? (lft_avg - rght_avg) : (rght_avg - lft_avg);
    gt_min_c = sum > ({1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS});
    lt_min_c = sum < ({1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS});
    d14_c    = {3'b000, diff, 2'b00} > {4'h0, sum};
    d1516_c  = {1'b0, diff, 4'h0} > (({4'h0, sum} << 4) - {4'h0, sum});
  end

  // Registered outputs; until the filter is full they show the rider-off view.
  always_ff @(posedge clk) begin
    if (rst || !filt_rdy) begin
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_1_4   <= 1'b0;
      diff_gt_15_16 <= 1'b0;
    end else begin
      sum_gt_min    <= gt_min_c;
      sum_lt_min    <= lt_min_c;
      diff_gt_1_4   <= d14_c;
      diff_gt_15_16 <= d1516_c;
    end
  end

  // Free-running timer that saturates; clearing takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clr_tmr) begin
      tmr_cnt <= '0;
    end else if (tmr_cnt != TMR_CNT) begin
      tmr_cnt <= tmr_cnt + 27'd1;
    end
  end

  assign tmr_full = (tmr_cnt == TMR_CNT);

endmodule

// File: doc/steer_en_sense.md
STEER_EN_SENSE -- requirements
Module: steer_en_sense

Interface
REQ-001 Parameter MIN_RIDER_WEIGHT, 12'h200, minimum combined rider load threshold.
REQ-002 Parameter HYSTERESIS, 12'h040, band applied either side of MIN_RIDER_WEIGHT.
REQ-003 Parameter TMR_CNT, 27'd65_000_000, timer terminal count: 1.3 s at 50 MHz.
REQ-004 clk  input  1  50 MHz clock; the only clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 lft_ld  input  12  left load cell A2D result, unsigned.
REQ-007 rght_ld  input  12  right load cell A2D result, unsigned.
REQ-008 ld_vld  input  1  single-cycle strobe; lft_ld and rght_ld are valid together.
REQ-009 clr_tmr  input  1  clears the timer; driven by the steer-enable state machine.
REQ-010 sum_gt_min  output  1  filtered sum > MIN_RIDER_WEIGHT+HYSTERESIS.
REQ-011 sum_lt_min  output  1  filtered sum < MIN_RIDER_WEIGHT-HYSTERESIS.
REQ-012 diff_gt_1_4  output  1  filtered |lft-rght| > sum/4.
REQ-013 diff_gt_15_16  output  1  filtered |lft-rght| > 15*sum/16.
REQ-014 tmr_full  output  1  timer has reached TMR_CNT.

Function
REQ-015 Each side shall keep a 4-deep sample history and a 14-bit running sum; all history, sums and counters shall be unsigned with no truncation.
REQ-016 On a clk edge with ld_vld=1: shift the new sample into each history, drop the oldest, and update acc <= acc + new - oldest in the same edge.
REQ-017 Filtered values lft_avg and rght_avg shall be acc[13:2], 12 bits each.
REQ-018 Arithmetic widths: sum = lft_avg + rght_avg, 13 bits; diff = |lft_avg - rght_avg|, 12 bits.
REQ-019 Comparisons: diff_gt_1_4 is 4*diff > sum; diff_gt_15_16 is 16*diff > 15*sum; both shall be evaluated at 17-bit width.
REQ-020 A 3-bit fill counter shall count ld_vld strobes, saturating at 4; filt_rdy = (fill == 4).
REQ-021 While filt_rdy=0, outputs shall be forced to sum_gt_min=0, sum_lt_min=1, diff_gt_1_4=0, diff_gt_15_16=0 (rider-off view).
REQ-022 All four comparison outputs shall be registered; they reflect a sample strobed at edge N at edge N+1 (observed in cycle N+1 onward, two-edge latency from ld_vld assertion).
REQ-023 Comparison outputs shall hold between ld_vld strobes.
REQ-024 sum_gt_min and sum_lt_min shall never be 1 simultaneously; both 0 inside the hysteresis band.
REQ-025 With sum=0, diff_gt_1_4 and diff_gt_15_16 shall be 0.
REQ-026 Timer: 27-bit counter; clr_tmr=1 sets it to 0 (priority over counting); otherwise it increments by 1 per cycle and saturates at TMR_CNT.
REQ-027 tmr_full shall be 1 exactly while count == TMR_CNT, decoded from the registered count.
REQ-028 clr_tmr while tmr_full=1 shall drop tmr_full in the cycle after the clearing edge.
REQ-029 The timer shall run independently of ld_vld and filt_rdy.
REQ-030 ld_vld and clr_tmr in the same cycle shall both take effect.

Reset
REQ-031 rst=1 at a clk edge shall clear histories, accumulators, fill counter and timer count to 0.
REQ-032 Reset values: sum_gt_min=0, sum_lt_min=1, diff_gt_1_4=0, diff_gt_15_16=0, tmr_full=0.
REQ-033 rst shall take priority over ld_vld and clr_tmr; reset mid-fill shall restart the fill from 0.
REQ-034 There shall be no asynchronous reset path.

Verification
REQ-035 Reset, then 3 strobes of lft=rght=12'h300 -> outputs remain at reset values; 4th strobe -> sum_gt_min=1, sum_lt_min=0, diffs 0 after 2 edges.
REQ-036 Hysteresis: filtered lft=rght=12'h100, sum 12'h200 -> both sum flags 0; lft=rght=12'h0D0 -> sum_lt_min=1; lft=rght=12'h130 -> sum_gt_min=1.
REQ-037 Difference: filtered lft=12'h300, rght=12'h100 -> diff_gt_1_4=1, diff_gt_15_16=0; lft=12'h400, rght=0 -> both 1.
REQ-038 Timer: clr_tmr pulse, then TMR_CNT idle cycles -> tmr_full rises exactly then and holds; a further clr_tmr -> tmr_full=0 the next cycle.
REQ-039 Simultaneous: clr_tmr with ld_vld -> timer=0 and the sample is accepted; rst asserted mid-fill -> fill restarts and outputs return to reset values.
